snes_poller: RTL

//  Sequences the shared latch/clock lines of up to eight SNES pads and shifts in

---
 rtl/snes_poller.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/snes_poller.sv
// Drives the shared latch/clock lines of eight SNES pads and captures
// 12 button bits per pad, publishing them atomically per frame.
module snes_poller #(
  parameter int HALF_TICK   = 300,
  parameter int POLL_CYCLES = 833333
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  snes_data,
  output logic        snes_latch,
  output logic        snes_clk,
  output logic [11:0] snes_0,
  output logic [11:0] snes_1,
  output logic [11:0] snes_2,
  output logic [11:0] snes_3,
  output logic [11:0] snes_4,
  output logic [11:0] snes_5,
  output logic [11:0] snes_6,
  output logic [11:0] snes_7,
  output logic        frame_done
);

  localparam int MAXC =
    (POLL_CYCLES > 2 * HALF_TICK) ? POLL_CYCLES : 2 * HALF_TICK;
  localparam int CW = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] POLL_LAST  = CW'(POLL_CYCLES - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(2 * HALF_TICK - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_TICK - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCH,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [3:0]     r_bit;
  logic           r_hi;
  logic           r_latch;
  logic           r_sclk;
  logic           r_done;
  logic [7:0]     r_s1;
  logic [7:0]     r_s2;
  logic [11:0]    r_sh  [8];
  logic [11:0]    r_btn [8];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 8'hFF;
      r_s2 <= 8'hFF;
    end else begin
      r_s1 <= snes_data;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_hi    <= 1'b0;
      r_latch <= 1'b0;
      r_sclk  <= 1'b1;
      r_done  <= 1'b0;
      for (int p = 0; p < 8; p++) begin
        r_sh[p]  <= '0;
        r_btn[p] <= '0;
      end
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_latch <= 1'b0;
          r_sclk  <= 1'b1;
          if (enable) begin
            if (r_cnt == POLL_LAST) begin
              r_state <= S_LATCH;
              r_cnt   <= '0;
              r_latch <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_LATCH: begin
          if (r_cnt == LATCH_LAST) begin
            r_state <= S_SHIFT;
            r_cnt   <= '0;
            r_latch <= 1'b0;
            r_sclk  <= 1'b0;
            r_hi    <= 1'b0;
            r_bit   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (r_cnt != HALF_LAST) begin
            r_cnt <= r_cnt + 1'b1;
          end else if (!r_hi) begin
            // bits 12..15 carry no buttons, so only 0..11 are kept
            if (r_bit < 4'd12) begin
              for (int p = 0; p < 8; p++)
                r_sh[p] <= {~r_s2[p], r_sh[p][11:1]};
            end
            r_cnt  <= '0;
            r_sclk <= 1'b1;
            r_hi   <= 1'b1;
          end else if (r_bit == 4'd15) begin
            r_cnt   <= '0;
            r_state <= S_DONE;
            r_done  <= 1'b1;
            for (int p = 0; p < 8; p++)
              r_btn[p] <= r_sh[p];
          end else begin
            r_cnt  <= '0;
            r_bit  <= r_bit + 4'd1;
            r_sclk <= 1'b0;
            r_hi   <= 1'b0;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign snes_latch = r_latch;
  assign snes_clk   = r_sclk;
  assign frame_done = r_done;
  assign snes_0     = r_btn[0];
  assign snes_1     = r_btn[1];
  assign snes_2     = r_btn[2];
  assign snes_3     = r_btn[3];
  assign snes_4     = r_btn[4];
  assign snes_5     = r_btn[5];
  assign snes_6     = r_btn[6];
  assign snes_7     = r_btn[7];

endmodule
